ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS core.
- Sits directly downstream of the ALU control decoder and consumes its 3-bit ALU_control code.
- Applies forwarding muxes and the ALU_src mux, performs the ALU operation, and registers the result with pass-through control into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insert).

Parameters:
- WIDTH, 32, datapath width in bits.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ALU_control  input  3  operation code from ALU control decoder
- rs_data  input  WIDTH  ID/EX register read data A
- rt_data  input  WIDTH  ID/EX register read data B
- imm_ext  input  WIDTH  sign-extended immediate
- ALU_src  input  1  1 = operand B is imm_ext, 0 = forwarded rt
- forward_a  input  2  00 = rs_data, 10 = exmem_fwd, 01 = memwb_fwd, 11 = rs_data
- forward_b  input  2  same encoding, applied to rt_data
- exmem_fwd  input  WIDTH  forwarded EX/MEM ALU result
- memwb_fwd  input  WIDTH  forwarded MEM/WB write-back data
- dest_reg_in  input  REG_ADDR_W  destination register (already rt/rd selected)
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in  input  1 each  pass-through control
- valid_in  input  1  ID/EX slot holds a real instruction
- stall  input  1  hold EX/MEM register
- flush  input  1  load bubble into EX/MEM register
- alu_result  output  WIDTH  registered ALU result
- zero  output  1  registered, result == 0
- store_data  output  WIDTH  registered forwarded operand B (before the ALU_src mux)
- dest_reg_out  output  REG_ADDR_W  registered destination
- reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, branch_out  output  1 each  registered control
- valid_out  output  1  registered valid

Behaviour:
- Operand path:
  - op_a = fwd_mux(forward_a).
  - fwd_b = fwd_mux(forward_b).
  - op_b = ALU_src ? imm_ext : fwd_b.
- ALU operations:
  - 010 add: op_a + op_b, mod 2^WIDTH.
  - 110 sub: op_a - op_b, mod 2^WIDTH.
  - 000 and.
  - 001 or.
  - 111 slt: signed two's-complement compare; result is 1 if op_a < op_b, else 0, zero-extended.
  - Any other code: result 0.
- Zero flag: computed on the raw combinational result, registered with it.
- Latency: exactly 1 cycle from inputs to registered outputs; no combinational input-to-output path.
- Reset (asynchronous, immediate):
  - All outputs 0, including valid_out and all control outputs.
  - Reset asserted mid-operation discards the in-flight instruction.
- Each rising clk edge, priority highest first:
  - flush=1: valid_out and all control outputs go to 0. alu_result, zero, store_data and dest_reg_out go to 0.
  - stall=1: all outputs hold their previous values.
  - Otherwise: all outputs load the new computed values.
- flush and stall both asserted: flush wins.
- valid_in=0 without flush: data is captured, but all control outputs are forced to 0 and valid_out=0. A bubble never writes registers or memory.
- There is no internal state beyond the EX/MEM register; no FSM.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, registered, reset 0).
  - overflow is set on signed overflow of add or sub:
    - add: operands have the same sign and the result sign differs.
    - sub: operands have different signs and the result sign differs from op_a.
  - When overflow=1, reg_write_out is forced to 0 for that instruction.
  - overflow follows the same stall, flush and bubble rules as the control outputs.
- Not defined:
  - No overflow port.
  - Add and sub wrap silently.
  - reg_write_out passes through unchanged.

Test Plan:
- Reset: assert reset mid-cycle with valid traffic -> all outputs 0 immediately, without waiting for clk.
- ALU ops, each with rs=0x0000000A, rt=0x00000003, ALU_src=0, forward=00:
  - add -> 0x0000000D.
  - sub -> 0x00000007.
  - and -> 0x00000002.
  - or -> 0x0000000B.
  - slt -> 0.
  - Swap operands and repeat slt -> 1.
  - sub with 5,5 -> zero=1.
- Signed slt: rs=0xFFFFFFFF, rt=0x00000001, code 111 -> 0x00000001. Code 011 -> 0x00000000 with zero=1.
- Forwarding:
  - forward_a=10 with exmem_fwd=0x100 and forward_b=01 with memwb_fwd=0x20, add -> 0x120.
  - ALU_src=1 with imm_ext=0x4 -> result 0x104, and store_data = 0x20.
- Stall and flush:
  - Stall for 2 cycles -> outputs held.
  - stall+flush together -> valid_out=0, reg_write_out=0 next edge.
  - valid_in=0 with mem_write_in=1 -> mem_write_out=0.
- ALU_OVERFLOW_EN:
  - Add 0x7FFFFFFF + 1 -> overflow=1, reg_write_out=0, alu_result=0x80000000.
  - Without the macro -> same result and reg_write_out=1.

Source files
------------

// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: operand, control and result bundle for the EX stage.
// The master side drives the ID/EX operands and control; the slave side is the
// EX stage, which drives the EX/MEM register outputs.
// Optional macro ALU_OVERFLOW_EN adds the registered overflow flag.
interface ex_alu_stage_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic [2:0]            ALU_control;
    logic [WIDTH-1:0]      rs_data;
    logic [WIDTH-1:0]      rt_data;
    logic [WIDTH-1:0]      imm_ext;
    logic                  ALU_src;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [WIDTH-1:0]      exmem_fwd;
    logic [WIDTH-1:0]      memwb_fwd;
    logic [REG_ADDR_W-1:0] dest_reg_in;
    logic                  reg_write_in;
    logic                  mem_read_in;
    logic                  mem_write_in;
    logic                  mem_to_reg_in;
    logic                  branch_in;
    logic                  valid_in;
    logic                  stall;
    logic                  flush;

    logic [WIDTH-1:0]      alu_result;
    logic                  zero;
    logic [WIDTH-1:0]      store_data;
    logic [REG_ADDR_W-1:0] dest_reg_out;
    logic                  reg_write_out;
    logic                  mem_read_out;
    logic                  mem_write_out;
    logic                  mem_to_reg_out;
    logic                  branch_out;
    logic                  valid_out;
`ifdef ALU_OVERFLOW_EN
    logic                  overflow;
`endif

    modport master (
        output ALU_control, rs_data, rt_data, imm_ext, ALU_src,
               forward_a, forward_b, exmem_fwd, memwb_fwd, dest_reg_in,
               reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in,
               branch_in, valid_in, stall, flush,
        input  alu_result, zero, store_data, dest_reg_out, reg_write_out,
               mem_read_out, mem_write_out, mem_to_reg_out, branch_out,
`ifdef ALU_OVERFLOW_EN
               overflow,
`endif
               valid_out
    );

    modport slave (
        input  ALU_control, rs_data, rt_data, imm_ext, ALU_src,
               forward_a, forward_b, exmem_fwd, memwb_fwd, dest_reg_in,
               reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in,
               branch_in, valid_in, stall, flush,
        output alu_result, zero, store_data, dest_reg_out, reg_write_out,
               mem_read_out, mem_write_out, mem_to_reg_out, branch_out,
`ifdef ALU_OVERFLOW_EN
               overflow,
`endif
               valid_out
    );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: MIPS execute stage. Forwarding muxes, ALU_src mux, ALU and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
// Optional macro ALU_OVERFLOW_EN: registered signed-overflow flag for add/sub
// that also suppresses reg_write_out for the overflowing instruction.
module ex_alu_stage #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic           clk,
    input logic           reset,
    ex_alu_stage_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_reg_write;

    logic [WIDTH-1:0]      r_alu_result;
    logic                  r_zero;
    logic [WIDTH-1:0]      r_store_data;
    logic [REG_ADDR_W-1:0] r_dest_reg;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_to_reg;
    logic                  r_branch;
    logic                  r_valid;
    logic                  r_ovf;

    // Forwarding muxes for both operands, then immediate select for B
    always_comb begin
        w_op_a = bus.rs_data;
        case (bus.forward_a)
            2'b10:   w_op_a = bus.exmem_fwd;
            2'b01:   w_op_a = bus.memwb_fwd;
            default: w_op_a = bus.rs_data;
        endcase
        w_fwd_b = bus.rt_data;
        case (bus.forward_b)
            2'b10:   w_fwd_b = bus.exmem_fwd;
            2'b01:   w_fwd_b = bus.memwb_fwd;
            default: w_fwd_b = bus.rt_data;
        endcase
        w_op_b = bus.ALU_src ? bus.imm_ext : w_fwd_b;
    end

    // ALU operation select; unknown codes yield zero
    always_comb begin
        w_sum    = w_op_a + w_op_b;
        w_diff   = w_op_a - w_op_b;
        w_result = '0;
        case (alu_op_e'(bus.ALU_control))
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_AND:  w_result = w_op_a & w_op_b;
            OP_OR:   w_result = w_op_a | w_op_b;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: w_result = '0;
        endcase
    end

    // Signed overflow detection for add/sub and the resulting write suppression
    always_comb begin
        w_ovf = 1'b0;
`ifdef ALU_OVERFLOW_EN
        if (bus.ALU_control == OP_ADD)
            w_ovf = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);
        else if (bus.ALU_control == OP_SUB)
            w_ovf = (w_op_a[WIDTH-1] != w_op_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_op_a[WIDTH-1]);
`endif
        w_reg_write = bus.reg_write_in & bus.valid_in & ~w_ovf;
    end

    // EX/MEM register: reset > flush > stall > load; bubbles carry data but no control
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_store_data <= '0;
            r_dest_reg   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (!bus.stall) begin
            r_alu_result <= w_result;
            r_zero       <= (w_result == '0);
            r_store_data <= w_fwd_b;
            r_dest_reg   <= bus.dest_reg_in;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= bus.mem_read_in & bus.valid_in;
            r_mem_write  <= bus.mem_write_in & bus.valid_in;
            r_mem_to_reg <= bus.mem_to_reg_in & bus.valid_in;
            r_branch     <= bus.branch_in & bus.valid_in;
            r_valid      <= bus.valid_in;
            r_ovf        <= w_ovf & bus.valid_in;
        end
    end

    assign bus.alu_result     = r_alu_result;
    assign bus.zero           = r_zero;
    assign bus.store_data     = r_store_data;
    assign bus.dest_reg_out   = r_dest_reg;
    assign bus.reg_write_out  = r_reg_write;
    assign bus.mem_read_out   = r_mem_read;
    assign bus.mem_write_out  = r_mem_write;
    assign bus.mem_to_reg_out = r_mem_to_reg;
    assign bus.branch_out     = r_branch;
    assign bus.valid_out      = r_valid;
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow       = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vectors with hand-computed expectations for the
// EX stage, checked with immediate assertions.
module tb_ex_alu_stage;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ex_alu_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

    ex_alu_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.ALU_control = code;
        bus.rs_data     = a;
        bus.rt_data     = b;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.ALU_control   = 3'b010;
        bus.rs_data       = 32'h0000000A;
        bus.rt_data       = 32'h00000003;
        bus.imm_ext       = 32'h0;
        bus.ALU_src       = 1'b0;
        bus.forward_a     = 2'b00;
        bus.forward_b     = 2'b00;
        bus.exmem_fwd     = 32'h0;
        bus.memwb_fwd     = 32'h0;
        bus.dest_reg_in   = 5'd7;
        bus.reg_write_in  = 1'b1;
        bus.mem_read_in   = 1'b0;
        bus.mem_write_in  = 1'b0;
        bus.mem_to_reg_in = 1'b0;
        bus.branch_in     = 1'b0;
        bus.valid_in      = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        #2;
        check("rst_valid", 32'(bus.valid_out), 32'h0);
        check("rst_result", bus.alu_result, 32'h0);
        check("rst_regwr", 32'(bus.reg_write_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ALU operations on 10, 3
        op(3'b010, 32'h0000000A, 32'h00000003);
        check("add", bus.alu_result, 32'h0000000D);
        check("add_zero", 32'(bus.zero), 32'h0);
        check("add_valid", 32'(bus.valid_out), 32'h1);
        check("add_regwr", 32'(bus.reg_write_out), 32'h1);
        check("add_dest", 32'(bus.dest_reg_out), 32'h7);
        check("add_store", bus.store_data, 32'h00000003);
        op(3'b110, 32'h0000000A, 32'h00000003);
        check("sub", bus.alu_result, 32'h00000007);
        op(3'b000, 32'h0000000A, 32'h00000003);
        check("and", bus.alu_result, 32'h00000002);
        op(3'b001, 32'h0000000A, 32'h00000003);
        check("or", bus.alu_result, 32'h0000000B);
        op(3'b111, 32'h0000000A, 32'h00000003);
        check("slt_ge", bus.alu_result, 32'h0);
        check("slt_ge_zero", 32'(bus.zero), 32'h1);
        op(3'b111, 32'h00000003, 32'h0000000A);
        check("slt_lt", bus.alu_result, 32'h1);
        op(3'b110, 32'h00000005, 32'h00000005);
        check("sub_eq", bus.alu_result, 32'h0);
        check("sub_eq_zero", 32'(bus.zero), 32'h1);
        op(3'b111, 32'hFFFFFFFF, 32'h00000001);
        check("slt_signed", bus.alu_result, 32'h1);
        op(3'b011, 32'hFFFFFFFF, 32'h00000001);
        check("undef_op", bus.alu_result, 32'h0);
        check("undef_zero", 32'(bus.zero), 32'h1);

        // Forwarding and immediate select
        bus.forward_a = 2'b10;
        bus.forward_b = 2'b01;
        bus.exmem_fwd = 32'h00000100;
        bus.memwb_fwd = 32'h00000020;
        op(3'b010, 32'h0000AAAA, 32'h0000BBBB);
        check("fwd_add", bus.alu_result, 32'h00000120);
        check("fwd_store", bus.store_data, 32'h00000020);
        bus.forward_a = 2'b11;
        op(3'b010, 32'h0000AAAA, 32'h0000BBBB);
        check("fwd11_add", bus.alu_result, 32'h0000AACA);
        bus.forward_a = 2'b10;
        bus.ALU_src   = 1'b1;
        bus.imm_ext   = 32'h00000004;
        op(3'b010, 32'h0000AAAA, 32'h0000BBBB);
        check("imm_add", bus.alu_result, 32'h00000104);
        check("imm_store", bus.store_data, 32'h00000020);

        // Stall holds for two edges despite changed inputs
        bus.stall       = 1'b1;
        bus.ALU_src     = 1'b0;
        bus.forward_a   = 2'b00;
        bus.forward_b   = 2'b00;
        bus.dest_reg_in = 5'd3;
        bus.valid_in    = 1'b0;
        op(3'b001, 32'h0000000F, 32'h000000F0);
        tick();
        check("stall_result", bus.alu_result, 32'h00000104);
        check("stall_store", bus.store_data, 32'h00000020);
        check("stall_valid", 32'(bus.valid_out), 32'h1);
        check("stall_dest", 32'(bus.dest_reg_out), 32'h7);

        // Flush wins over stall
        bus.valid_in = 1'b1;
        bus.flush    = 1'b1;
        tick();
        check("flush_valid", 32'(bus.valid_out), 32'h0);
        check("flush_regwr", 32'(bus.reg_write_out), 32'h0);
        check("flush_result", bus.alu_result, 32'h0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Bubble: data captured, control forced off
        bus.valid_in     = 1'b0;
        bus.mem_write_in = 1'b1;
        op(3'b010, 32'h0000000A, 32'h00000003);
        check("bub_result", bus.alu_result, 32'h0000000D);
        check("bub_memwr", 32'(bus.mem_write_out), 32'h0);
        check("bub_valid", 32'(bus.valid_out), 32'h0);
        check("bub_regwr", 32'(bus.reg_write_out), 32'h0);

        // Control pass-through on a valid instruction
        bus.valid_in      = 1'b1;
        bus.mem_read_in   = 1'b1;
        bus.mem_to_reg_in = 1'b1;
        bus.branch_in     = 1'b1;
        op(3'b010, 32'h00000001, 32'h00000002);
        check("ctl_memwr", 32'(bus.mem_write_out), 32'h1);
        check("ctl_memrd", 32'(bus.mem_read_out), 32'h1);
        check("ctl_m2r", 32'(bus.mem_to_reg_out), 32'h1);
        check("ctl_branch", 32'(bus.branch_out), 32'h1);
        bus.mem_read_in   = 1'b0;
        bus.mem_write_in  = 1'b0;
        bus.mem_to_reg_in = 1'b0;
        bus.branch_in     = 1'b0;

        // Signed overflow boundary
        op(3'b010, 32'h7FFFFFFF, 32'h00000001);
        check("ovf_result", bus.alu_result, 32'h80000000);
`ifdef ALU_OVERFLOW_EN
        check("ovf_flag", 32'(bus.overflow), 32'h1);
        check("ovf_regwr", 32'(bus.reg_write_out), 32'h0);
        op(3'b110, 32'h80000000, 32'h00000001);
        check("ovf_sub_flag", 32'(bus.overflow), 32'h1);
        op(3'b010, 32'h00000001, 32'h00000001);
        check("noovf_flag", 32'(bus.overflow), 32'h0);
        check("noovf_regwr", 32'(bus.reg_write_out), 32'h1);
`else
        check("ovf_regwr", 32'(bus.reg_write_out), 32'h1);
`endif

        // Asynchronous reset mid-cycle discards the in-flight result
        op(3'b010, 32'h0000000A, 32'h00000003);
        check("pre_rst_valid", 32'(bus.valid_out), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(bus.valid_out), 32'h0);
        check("arst_result", bus.alu_result, 32'h0);
        check("arst_regwr", 32'(bus.reg_write_out), 32'h0);
        check("arst_store", bus.store_data, 32'h0);
        tick();
        check("arst_hold", 32'(bus.valid_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
